// File: rtl/cache_assoc_nway.sv
// N-way set-associative, write-back / write-allocate cache with true-LRU replacement.
// One word per line; misses use a req/ack handshake to a word-addressed backing memory.
module cache_assoc_nway #(
    parameter  int ADDR_W = 4,
    parameter  int IDX_W  = 2,
    parameter  int WAYS   = 2,
    parameter  int DATA_W = 8,
    localparam int AGE_W  = $clog2(WAYS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilita,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     endereco,
    input  logic [DATA_W-1:0]     dado,
    output logic                  ready,
    output logic                  done,
    output logic                  hit,
    output logic                  wb,
    output logic [DATA_W-1:0]     q,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [WAYS*AGE_W-1:0] lru_set
);
    localparam int SETS  = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WBACK, S_FILL, S_DONE} state_t;
    state_t state_q, state_d;

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic [AGE_W-1:0]  victim_q;
    logic              hit_q;
    logic              wb_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              lookup_hit;
    logic              any_invalid;
    logic              victim_dirty;
    logic              ack_valid;
    logic              touch_en;
    logic [AGE_W-1:0]  hit_way;
    logic [AGE_W-1:0]  invalid_way;
    logic [AGE_W-1:0]  lru_way;
    logic [AGE_W-1:0]  victim_way;
    logic [AGE_W-1:0]  touch_way;

    assign req_idx   = req_addr_q[IDX_W-1:0];
    assign req_tag   = req_addr_q[ADDR_W-1:IDX_W];
    // An ack only counts while a request is actually outstanding.
    assign ack_valid = mem_req && mem_ack;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        lookup_hit  = 1'b0;
        any_invalid = 1'b0;
        hit_way     = '0;
        invalid_way = '0;
        lru_way     = '0;
        // Descending scan: the last assignment wins, giving the lowest-index invalid way.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                lookup_hit = 1'b1;
                hit_way    = AGE_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                any_invalid = 1'b1;
                invalid_way = AGE_W'(w);
            end
            if (age_q[req_idx][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
        victim_way   = any_invalid ? invalid_way : lru_way;
        victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
    end

    always_comb begin
        state_d = state_q;
        ready   = (state_q == S_IDLE);
        done    = (state_q == S_DONE);
        hit     = done && hit_q;
        wb      = done && wb_q;
        unique case (state_q)
            S_IDLE:    if (habilita) state_d = S_COMPARE;
            S_COMPARE: begin
                if (lookup_hit)        state_d = S_DONE;
                else if (victim_dirty) state_d = S_WBACK;
                else                   state_d = S_FILL;
            end
            S_WBACK:   if (ack_valid) state_d = S_FILL;
            S_FILL:    if (ack_valid) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign touch_en  = ((state_q == S_COMPARE) && lookup_hit) || ((state_q == S_FILL) && ack_valid);
    assign touch_way = (state_q == S_COMPARE) ? hit_way : victim_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the line arrays are plain registers, so reset clears them and seeds a valid LRU permutation.
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            victim_q   <= '0;
            hit_q      <= 1'b0;
            wb_q       <= 1'b0;
            q          <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    wb_q <= 1'b0;
                    if (habilita) begin
                        req_we_q   <= we;
                        req_addr_q <= endereco;
                        req_data_q <= dado;
                    end
                end
                S_COMPARE: begin
                    hit_q    <= lookup_hit;
                    victim_q <= victim_way;
                    if (lookup_hit) begin
                        if (req_we_q) begin
                            data_q[req_idx][hit_way]  <= req_data_q;
                            dirty_q[req_idx][hit_way] <= 1'b1;
                            q                         <= req_data_q;
                        end else begin
                            q <= data_q[req_idx][hit_way];
                        end
                    end else begin
                        mem_req <= 1'b1;
                        if (victim_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[req_idx][victim_way], req_idx};
                            mem_wdata <= data_q[req_idx][victim_way];
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= req_addr_q;
                        end
                    end
                end
                S_WBACK: begin
                    if (ack_valid) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        wb_q    <= 1'b1;
                    end
                end
                S_FILL: begin
                    // After a write-back the request is re-raised one cycle later, leaving an idle gap.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr_q;
                    end else if (mem_ack) begin
                        mem_req                    <= 1'b0;
                        valid_q[req_idx][victim_q] <= 1'b1;
                        tag_q[req_idx][victim_q]   <= req_tag;
                        dirty_q[req_idx][victim_q] <= req_we_q;
                        data_q[req_idx][victim_q]  <= req_we_q ? req_data_q : mem_rdata;
                        q                          <= req_we_q ? req_data_q : mem_rdata;
                    end
                end
                default: ;
            endcase

            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way)
                        age_q[req_idx][w] <= '0;
                    else if (age_q[req_idx][w] < age_q[req_idx][touch_way])
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_set = '0;
        for (int w = 0; w < WAYS; w++) begin
            lru_set[w*AGE_W +: AGE_W] = age_q[endereco[IDX_W-1:0]][w];
        end
    end

endmodule

// File: tb/tb_cache_assoc_nway.sv
// Bench for cache_assoc_nway: directed scenarios plus randomized traffic checked against a
// recency-list cache model and a bench-side backing memory with randomized ack latency.
module tb_cache_assoc_nway;
    localparam int ADDR_W = 4;
    localparam int IDX_W  = 2;
    localparam int WAYS   = 2;
    localparam int DATA_W = 8;
    localparam int SETS   = 2 ** IDX_W;
    localparam int AGE_W  = $clog2(WAYS);
    localparam int LRU_W  = WAYS * AGE_W;

    typedef struct { logic hit; logic wb; logic [DATA_W-1:0] q; int acc_cyc; } exp_t;
    typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } txn_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              habilita = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] endereco = '0;
    logic [DATA_W-1:0] dado = '0;
    logic              ready, done, hit, wb;
    logic [DATA_W-1:0] q;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [LRU_W-1:0]  lru_set;

    cache_assoc_nway #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .WAYS(WAYS), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .we(we), .endereco(endereco),
        .dado(dado), .ready(ready), .done(done), .hit(hit), .wb(wb), .q(q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .lru_set(lru_set)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model: per-set way contents plus a recency list (position 0 = most recent).
    logic              m_valid [SETS][WAYS];
    logic              m_dirty [SETS][WAYS];
    int                m_tag   [SETS][WAYS];
    logic [DATA_W-1:0] m_data  [SETS][WAYS];
    int                order   [SETS][WAYS];
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] mem     [2**ADDR_W];

    exp_t exp_q[$];
    txn_t exp_tx[$];
    txn_t obs_tx[$];
    txn_t last_obs[$];

    logic mem_hold  = 1'b0;
    logic stray_ack = 1'b0;
    int   done_count = 0;
    logic last_hit, last_wb;
    int   last_lat;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                order[s][w]   = w;
            end
    endfunction

    function automatic void touch(input int s, input int way);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (order[s][i] == way) p = i;
        for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
        order[s][0] = way;
    endfunction

    function automatic logic [LRU_W-1:0] model_lru(input int s);
        logic [LRU_W-1:0] r = '0;
        for (int p = 0; p < WAYS; p++) r[order[s][p]*AGE_W +: AGE_W] = AGE_W'(p);
        return r;
    endfunction

    function automatic void model_predict(input logic w, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d, input int acc);
        int   s   = int'(a) % SETS;
        int   t   = int'(a) / SETS;
        int   way = -1;
        exp_t e;
        for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) way = i;
        e.acc_cyc = acc;
        e.wb      = 1'b0;
        if (way >= 0) begin
            e.hit = 1'b1;
            if (w) begin
                m_data[s][way]  = d;
                m_dirty[s][way] = 1'b1;
            end
        end else begin
            e.hit = 1'b0;
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) way = i;
            if (way < 0) way = order[s][WAYS-1];
            if (m_valid[s][way] && m_dirty[s][way]) begin
                e.wb = 1'b1;
                exp_tx.push_back(txn_t'{1'b1, ADDR_W'(m_tag[s][way] * SETS + s), m_data[s][way]});
                ref_mem[m_tag[s][way] * SETS + s] = m_data[s][way];
            end
            exp_tx.push_back(txn_t'{1'b0, a, '0});
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = t;
            m_dirty[s][way] = w;
            m_data[s][way]  = w ? d : ref_mem[a];
        end
        e.q = m_data[s][way];
        touch(s, way);
        exp_q.push_back(e);
    endfunction

    // Backing memory: acks after a random 0..3 cycle wait, one-cycle ack pulse.
    int   wait_cnt = 0;
    logic prev_ack = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (prev_ack) check("req_gap_after_ack", 32'(mem_req), 32'(0));
            prev_ack = 1'b0;
            mem_ack  = 1'b0;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
                stray_ack = 1'b0;
            end else if (mem_req && !mem_hold) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    obs_tx.push_back(txn_t'{mem_we, mem_addr, mem_wdata});
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    mem_rdata = mem[mem_addr];
                    mem_ack   = 1'b1;
                    prev_ack  = 1'b1;
                    wait_cnt  = $urandom_range(0, 3);
                end
            end
        end
    end

    // Compare process: every done pulse is checked against the oldest model expectation.
    exp_t ce;
    txn_t ot, xt;
    initial begin
        forever begin
            @(negedge clock);
            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(1), 32'(0));
                end else begin
                    ce = exp_q.pop_front();
                    check("hit", 32'(hit), 32'(ce.hit));
                    check("wb", 32'(wb), 32'(ce.wb));
                    check("q", 32'(q), 32'(ce.q));
                    check("lru_set", 32'(lru_set), 32'(model_lru(int'(endereco) % SETS)));
                    if (ce.hit) check("hit_latency", 32'(cyc + 1 - ce.acc_cyc), 32'(2));
                    check("mem_txn_count", 32'(obs_tx.size()), 32'(exp_tx.size()));
                    last_hit = hit;
                    last_wb  = wb;
                    last_lat = cyc + 1 - ce.acc_cyc;
                    last_obs = obs_tx;
                    while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
                        ot = obs_tx.pop_front();
                        xt = exp_tx.pop_front();
                        check("mem_we", 32'(ot.we), 32'(xt.we));
                        check("mem_addr", 32'(ot.addr), 32'(xt.addr));
                        if (xt.we) check("mem_wdata", 32'(ot.wdata), 32'(xt.wdata));
                    end
                    obs_tx.delete();
                    exp_tx.delete();
                end
            end
        end
    end

    task automatic access(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int spam);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        model_predict(w, a, d, cyc + 1);
        we = w; endereco = a; dado = d; habilita = 1'b1;
        @(negedge clock);
        habilita = 1'b0;
        // Requests presented while busy must be ignored.
        for (int k = 0; k < spam; k++) begin
            habilita = !ready; we = 1'b1; dado = 8'hFF;
            @(negedge clock);
        end
        habilita = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_timeout", 32'(0), 32'(1));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; habilita = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        exp_q.delete(); exp_tx.delete(); obs_tx.delete();
    endtask

    int n_wait;
    int done_before;
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 8'($urandom);
        mem[3]  = 8'h11;
        ref_mem = mem;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_hit_wb", 32'({hit, wb}), 32'(0));
        check("rst_q", 32'(q), 32'(0));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_lru_set", 32'(lru_set), 32'(2'b10));

        access(1'b0, 4'h3, 8'h00, 0);
        check("lit_read3_q", 32'(q), 32'(8'h11));
        check("lit_read3_hit_wb", 32'({last_hit, last_wb}), 32'(2'b00));
        check("lit_read3_lru", 32'(lru_set), 32'(2'b10));
        check("lit_read3_ntx", 32'(last_obs.size()), 32'(1));
        if (last_obs.size() == 1) check("lit_read3_fill_addr", 32'(last_obs[0].addr), 32'(3));

        access(1'b1, 4'h1, 8'h5A, 0);
        access(1'b0, 4'h1, 8'h00, 0);
        check("lit_hit_flag", 32'(last_hit), 32'(1));
        check("lit_hit_q", 32'(q), 32'(8'h5A));
        check("lit_hit_latency", 32'(last_lat), 32'(2));
        check("lit_hit_no_mem", 32'(last_obs.size()), 32'(0));

        access(1'b0, 4'h5, 8'h00, 0);
        access(1'b0, 4'h9, 8'h00, 0);
        check("lit_evict_wb", 32'(last_wb), 32'(1));
        check("lit_evict_ntx", 32'(last_obs.size()), 32'(2));
        if (last_obs.size() == 2) begin
            check("lit_evict_wb_addr", 32'(last_obs[0].addr), 32'(1));
            check("lit_evict_wb_data", 32'(last_obs[0].wdata), 32'(8'h5A));
            check("lit_evict_fill_addr", 32'(last_obs[1].addr), 32'(9));
        end
        check("lit_mem1_written", 32'(mem[1]), 32'(8'h5A));

        access(1'b0, 4'h5, 8'h00, 0);
        check("lit_read5_hit", 32'(last_hit), 32'(1));
        access(1'b0, 4'h1, 8'h00, 0);
        access(1'b0, 4'h9, 8'h00, 0);
        check("lit_clean_victim_hit_wb", 32'({last_hit, last_wb}), 32'(2'b00));
        check("lit_clean_victim_ntx", 32'(last_obs.size()), 32'(1));

        do_reset();
        done_before = done_count;
        access(1'b0, 4'h2, 8'h00, 2);
        repeat (6) @(negedge clock);
        check("spam_single_done", 32'(done_count - done_before), 32'(1));
        check("spam_ready", 32'(ready), 32'(1));

        mem_hold = 1'b1;
        done_before = done_count;
        we = 1'b0; endereco = 4'h6; habilita = 1'b1;
        @(negedge clock);
        habilita = 1'b0;
        n_wait = 0;
        while (!mem_req && n_wait < 20) begin
            @(negedge clock);
            n_wait++;
        end
        check("abort_fill_req_seen", 32'(mem_req), 32'(1));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_mem_req_low", 32'(mem_req), 32'(0));
        check("abort_ready", 32'(ready), 32'(1));
        model_reset();
        exp_q.delete(); exp_tx.delete(); obs_tx.delete();
        stray_ack = 1'b1;
        repeat (4) @(negedge clock);
        check("stray_ack_ignored_ready", 32'(ready), 32'(1));
        check("stray_ack_ignored_req", 32'(mem_req), 32'(0));
        check("stray_ack_no_done", 32'(done_count - done_before), 32'(0));
        mem_hold = 1'b0;
        access(1'b0, 4'h2, 8'h00, 0);
        check("after_abort_invalid", 32'(last_hit), 32'(0));
        access(1'b0, 4'h6, 8'h00, 0);

        repeat (400) access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 0);

        repeat (3) @(negedge clock);
        check("no_pending_expectations", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
